axi_refill_ctl: RTL and testbench

//  Memory-side responder for the icache line-refill interface: takes a line request, issues one AXI4

---
 rtl/axi_refill_if.sv | 46 ++++
 rtl/axi_refill_ctl.sv | 129 ++++++++++++
 tb/tb_axi_refill_ctl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_refill_if.sv
// Bundle between the icache refill port, the refill controller and the AXI read channels.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1; valid must not drop while ready is 0.
interface axi_refill_if #(
  parameter int LINE_BYTES = 64,
  parameter int DATA_W     = 64
);
  localparam int IDX_W = $clog2(LINE_BYTES * 8);

  logic              cache_req;
  logic [63:0]       cache_req_addr;
  logic [IDX_W-1:0]  cache_fifo_idx;
  logic              cache_fifo_done;
  logic              cache_done;
  logic [DATA_W-1:0] cache_data_o;
  logic              cache_err;

  logic [63:0]       m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    input  cache_req, cache_req_addr, cache_fifo_idx, cache_fifo_done,
    output cache_done, cache_data_o, cache_err,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    output cache_req, cache_req_addr, cache_fifo_idx, cache_fifo_done,
    input  cache_done, cache_data_o, cache_err,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/axi_refill_ctl.sv
// icache line-refill controller: one AXI4 INCR burst per line into a local buffer,
// then beats are served to the cache by index until the cache releases the line.
module axi_refill_ctl #(
  parameter int LINE_BYTES = 64,
  parameter int DATA_W     = 64
) (
  input  logic               clk,
  input  logic               rst,
  axi_refill_if.master       bus,
  output logic [1:0]         dbg_state
);
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(DATA_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [63:0] LINE_MASK = 64'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [63:0]         araddr_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                done_q;
  logic                err_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [DATA_W-1:0]   line_buf [BEATS];

  logic take_req, ar_hs, r_hs, beat_bad, fill_done, release_line;
  logic [BEAT_W-1:0] beat_sel;

  always_comb begin
    state_d      = state_q;
    take_req     = 1'b0;
    ar_hs        = 1'b0;
    r_hs         = 1'b0;
    beat_bad     = 1'b0;
    fill_done    = 1'b0;
    release_line = 1'b0;
    case (state_q)
      IDLE: begin
        // fifo_done must be low so a release cycle is never mistaken for a new request
        if (bus.cache_req && !bus.cache_fifo_done) begin
          take_req = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && bus.m_arready) begin
          ar_hs   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.m_rvalid && rready_q) begin
          r_hs     = 1'b1;
          beat_bad = (bus.m_rresp != 2'b00) ||
                     (bus.m_rlast != (beat_cnt_q == LAST_BEAT));
          // The beat count, not rlast, decides when the line is complete
          if (beat_cnt_q == LAST_BEAT) begin
            fill_done = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (bus.cache_fifo_done) begin
          release_line = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
      for (int i = 0; i < BEATS; i++) line_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      if (take_req) begin
        araddr_q   <= bus.cache_req_addr & ~LINE_MASK;
        arvalid_q  <= 1'b1;
        err_q      <= 1'b0;
        beat_cnt_q <= '0;
      end
      if (ar_hs) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (r_hs) begin
        line_buf[beat_cnt_q] <= bus.m_rdata;
        beat_cnt_q           <= beat_cnt_q + 1'b1;
        if (beat_bad) err_q <= 1'b1;
      end
      if (fill_done) begin
        rready_q <= 1'b0;
        done_q   <= 1'b1;
      end
      if (release_line) done_q <= 1'b0;
    end
  end

  // cache_fifo_idx is a bit offset; dropping the in-beat offset leaves the beat number
  assign beat_sel = BEAT_W'(bus.cache_fifo_idx >> OFF_W);

  assign bus.cache_done   = done_q;
  assign bus.cache_err    = err_q;
  assign bus.cache_data_o = line_buf[beat_sel];
  assign bus.m_araddr     = araddr_q;
  assign bus.m_arlen      = 8'(BEATS - 1);
  assign bus.m_arsize     = 3'($clog2(DATA_W / 8));
  assign bus.m_arburst    = 2'b01;
  assign bus.m_arvalid    = arvalid_q;
  assign bus.m_rready     = rready_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_axi_refill_ctl.sv
// Directed bench for axi_refill_ctl: a driver plays icache and AXI memory, a negedge
// monitor pops expected AR addresses, completions and read data from queues.
module tb_axi_refill_ctl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  axi_refill_if #(.LINE_BYTES(64), .DATA_W(64)) bus ();

  axi_refill_ctl #(.LINE_BYTES(64), .DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  logic [63:0] exp_ar_q[$];
  done_t       exp_done_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] line_exp [8];
  logic        rd_chk;
  int          beats_seen;
  logic        done_prev;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (bus.m_arvalid) begin
        if (exp_ar_q.size() == 0) begin
          check("ar_unexpected", 64'd1, 64'd0);
        end else begin
          check("araddr", bus.m_araddr, exp_ar_q[0]);
          check("arlen", 64'(bus.m_arlen), 64'd7);
          check("arsize", 64'(bus.m_arsize), 64'd3);
          check("arburst", 64'(bus.m_arburst), 64'd1);
          if (bus.m_arready) begin
            void'(exp_ar_q.pop_front());
            beats_seen = 0;
          end
        end
      end
      if (bus.m_rvalid && bus.m_rready) beats_seen++;
      if (bus.cache_done && !done_prev) begin
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("cache_err", 64'(bus.cache_err), 64'(d.err));
          check("beats_at_done", 64'(beats_seen), 64'd8);
          check("rready_at_done", 64'(bus.m_rready), 64'd0);
          if (d.cyc >= 0) check("done_latency", 64'(cyc), 64'(d.cyc));
        end
      end
      if (rd_chk) begin
        if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("cache_data_o", bus.cache_data_o, exp_q.pop_front());
      end
      done_prev = bus.cache_done;
    end
  end

  // driver tasks
  task automatic run_line(input logic [63:0] addr, input int ar_wait, input bit toggle,
                          input int err_beat, input int rlast_beat, input bit exp_err,
                          input bit chk_lat, input logic [31:0] tag, input bit hold_req,
                          input int abort_after);
    int n;
    int b;
    done_t d;
    exp_ar_q.push_back(addr & ~64'h3f);
    if (abort_after >= 8) begin
      d.err = exp_err;
      d.cyc = chk_lat ? cyc + 10 : -1;
      exp_done_q.push_back(d);
    end
    bus.cache_req       = 1'b1;
    bus.cache_req_addr  = addr;
    bus.cache_fifo_done = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.m_arvalid && n < 20);
    if (!bus.m_arvalid) check("ar_timeout", 64'd0, 64'd1);
    check("err_cleared", 64'(bus.cache_err), 64'd0);
    check("state_addr", 64'(dbg_state), 64'd1);
    repeat (ar_wait) begin @(posedge clk); #1; end
    bus.m_arready = 1'b1;
    @(posedge clk); #1;
    bus.m_arready = 1'b0;
    b = 0;
    while (b < 8) begin
      line_exp[b]  = (64'(tag) << 32) | (64'(b) * 64'h1111);
      bus.m_rdata  = line_exp[b];
      bus.m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      bus.m_rlast  = (b == rlast_beat);
      bus.m_rvalid = 1'b1;
      @(posedge clk); #1;
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
      bus.m_rresp  = 2'b00;
      if (b < 7) check("early_done", 64'(bus.cache_done), 64'd0);
      if (b + 1 == abort_after) begin
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_arvalid", 64'(bus.m_arvalid), 64'd0);
        check("rst_rready", 64'(bus.m_rready), 64'd0);
        check("rst_done", 64'(bus.cache_done), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        bus.cache_fifo_idx = 9'd64;
        #1;
        check("rst_linebuf", bus.cache_data_o, 64'd0);
        bus.cache_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (toggle) begin @(posedge clk); #1; end
      b++;
    end
    n = 0;
    while (!bus.cache_done && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cache_done) check("done_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (i * 3) % 8;
      bus.cache_fifo_idx = 9'(k * 64 + $urandom_range(0, 63));
      exp_q.push_back(line_exp[k]);
      rd_chk = 1'b1;
      @(posedge clk); #1;
    end
    rd_chk = 1'b0;
    check("done_held", 64'(bus.cache_done), 64'd1);
    bus.cache_fifo_done = 1'b1;
    bus.cache_req       = hold_req;
    @(posedge clk); #1;
    check("done_release", 64'(bus.cache_done), 64'd0);
    check("state_idle", 64'(dbg_state), 64'd0);
    bus.cache_fifo_done = 1'b0;
    bus.cache_req       = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    rd_chk              = 1'b0;
    beats_seen          = 0;
    done_prev           = 1'b0;
    bus.cache_req       = 1'b0;
    bus.cache_req_addr  = '0;
    bus.cache_fifo_idx  = '0;
    bus.cache_fifo_done = 1'b0;
    bus.m_arready       = 1'b0;
    bus.m_rdata         = '0;
    bus.m_rresp         = 2'b00;
    bus.m_rlast         = 1'b0;
    bus.m_rvalid        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_arvalid", 64'(bus.m_arvalid), 64'd0);
    check("reset_rready", 64'(bus.m_rready), 64'd0);
    check("reset_done", 64'(bus.cache_done), 64'd0);
    check("reset_err", 64'(bus.cache_err), 64'd0);
    check("reset_araddr", bus.m_araddr, 64'd0);
    check("reset_data", bus.cache_data_o, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // zero-wait burst with latency check
    run_line(64'h8000_1234, 0, 1'b0, 8, 7, 1'b0, 1'b1, 32'h0, 1'b0, 8);
    // AR backpressure and gapped R beats
    run_line(64'h4000_0040, 5, 1'b1, 8, 7, 1'b0, 1'b0, 32'h2, 1'b0, 8);
    // SLVERR on third beat
    run_line(64'h4000_1080, 0, 1'b0, 2, 7, 1'b1, 1'b0, 32'h3, 1'b0, 8);
    // early rlast on fifth beat, request held through release
    run_line(64'h4000_2000, 0, 1'b0, 8, 4, 1'b1, 1'b0, 32'h4, 1'b1, 8);
    // re-request right after release
    run_line(64'h8000_2000, 0, 1'b0, 8, 7, 1'b0, 1'b1, 32'h5, 1'b0, 8);
    // async reset after four beats, then a clean line
    run_line(64'h8000_3000, 0, 1'b0, 8, 7, 1'b0, 1'b0, 32'h6, 1'b0, 4);
    run_line(64'h8000_3040, 2, 1'b0, 8, 7, 1'b0, 1'b0, 32'h7, 1'b0, 8);

    repeat (4) @(posedge clk);
    #1;
    check("ar_queue_empty", 64'(exp_ar_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    check("data_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
